// File: rtl/encoder_decoder.sv
`default_nettype none
// ============================================================================
// Module  : encoder_decoder
// Brief   : Quadrature decoder with input filter, velocity window and AXI-Lite
// Revision: 1.0
// ============================================================================
module encoder_decoder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        encoder_a,
   input  logic        encoder_b,
   input  logic [7:0]  CP_AWADDR,
   input  logic [2:0]  CP_AWPROT,
   input  logic        CP_AWVALID,
   output logic        CP_AWREADY,
   input  logic [63:0] CP_WDATA,
   input  logic [7:0]  CP_WSTRB,
   input  logic        CP_WVALID,
   output logic        CP_WREADY,
   output logic [1:0]  CP_BRESP,
   output logic        CP_BVALID,
   input  logic        CP_BREADY,
   input  logic [7:0]  CP_ARADDR,
   input  logic [2:0]  CP_ARPROT,
   input  logic        CP_ARVALID,
   output logic        CP_ARREADY,
   output logic [63:0] CP_RDATA,
   output logic [1:0]  CP_RRESP,
   output logic        CP_RVALID,
   input  logic        CP_RREADY
);

   localparam logic [7:0] c_ADDR_CTRL   = 8'h00;
   localparam logic [7:0] c_ADDR_POS    = 8'h08;
   localparam logic [7:0] c_ADDR_STATUS = 8'h10;
   localparam logic [7:0] c_ADDR_VWIN   = 8'h18;
   localparam logic [7:0] c_ADDR_VEL    = 8'h20;

   logic [SYNC_STAGES-1:0] r_sync_a, r_sync_b;
   logic [1:0]  r_cand, r_filt, r_prev;
   logic [8:0]  r_run;
   logic        r_filt_valid, r_primed;
   logic        r_enable, r_dir;
   logic [7:0]  r_filter;
   logic [31:0] r_pos, r_err_cnt, r_vel_window, r_win_cnt, r_acc, r_velocity;
   logic        r_awready, r_bvalid, r_arready, r_rvalid;
   logic [63:0] r_rdata;

   logic [1:0]  w_ab;
   logic [8:0]  w_run, w_need;
   logic        w_change, w_fwd, w_rev, w_err;
   logic [31:0] w_step_val;
   logic        w_wr_en, w_clr_pos, w_clr_err, w_vel_wr, w_rd_en;
   logic [63:0] w_rd_data;
   logic        w_unused;

   // Forward Gray order on {A,B}: 00 -> 10 -> 11 -> 01 -> 00
   function automatic logic [1:0] gray_next(input logic [1:0] s);
      case (s)
         2'b00:   gray_next = 2'b10;
         2'b10:   gray_next = 2'b11;
         2'b11:   gray_next = 2'b01;
         default: gray_next = 2'b00;
      endcase
   endfunction

   assign w_ab   = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
   assign w_run  = (w_ab != r_cand) ? 9'd1 : ((r_run == 9'd256) ? r_run : r_run + 9'd1);
   assign w_need = {1'b0, r_filter} + 9'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync_a     <= '0;
         r_sync_b     <= '0;
         r_cand       <= 2'b00;
         r_run        <= 9'd0;
         r_filt       <= 2'b00;
         r_filt_valid <= 1'b0;
      end else begin
         r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], encoder_a};
         r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], encoder_b};
         r_cand   <= w_ab;
         r_run    <= w_run;
         if (w_run >= w_need) begin
            r_filt       <= w_ab;
            r_filt_valid <= 1'b1;
         end
      end
   end

   assign w_change   = r_filt_valid && r_primed && (r_filt != r_prev);
   assign w_fwd      = r_enable && w_change && (r_filt == gray_next(r_prev));
   assign w_rev      = r_enable && w_change && (r_prev == gray_next(r_filt));
   assign w_err      = r_enable && w_change && ((r_filt ^ r_prev) == 2'b11);
   assign w_step_val = w_fwd ? 32'd1 : (w_rev ? 32'hFFFF_FFFF : 32'd0);

   assign w_wr_en   = r_awready && CP_AWVALID && CP_WVALID;
   assign w_clr_pos = w_wr_en && (CP_AWADDR == c_ADDR_CTRL) && CP_WSTRB[0] && CP_WDATA[1];
   assign w_clr_err = w_wr_en && (CP_AWADDR == c_ADDR_CTRL) && CP_WSTRB[0] && CP_WDATA[2];
   assign w_vel_wr  = w_wr_en && (CP_AWADDR == c_ADDR_VWIN) && (|CP_WSTRB[3:0]);
   assign w_rd_en   = r_arready && CP_ARVALID;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev    <= 2'b00;
         r_primed  <= 1'b0;
         r_pos     <= 32'd0;
         r_dir     <= 1'b0;
         r_err_cnt <= 32'd0;
      end else begin
         if (r_filt_valid && !r_primed) begin
            r_prev   <= r_filt;
            r_primed <= 1'b1;
         end else if (w_change) begin
            r_prev <= r_filt;
         end
         // Clears take priority over a step or error landing in the same cycle
         if (w_clr_pos)  r_pos <= 32'd0;
         else if (w_fwd) r_pos <= r_pos + 32'd1;
         else if (w_rev) r_pos <= r_pos - 32'd1;
         if (w_fwd)      r_dir <= 1'b1;
         else if (w_rev) r_dir <= 1'b0;
         if (w_clr_err) r_err_cnt <= 32'd0;
         else if (w_err && (r_err_cnt != 32'hFFFF_FFFF)) r_err_cnt <= r_err_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_win_cnt  <= 32'd0;
         r_acc      <= 32'd0;
         r_velocity <= 32'd0;
      end else if (w_vel_wr) begin
         r_win_cnt <= 32'd0;
         r_acc     <= 32'd0;
      end else if (r_vel_window != 32'd0) begin
         if (r_win_cnt == r_vel_window - 32'd1) begin
            r_velocity <= r_acc + w_step_val;
            r_acc      <= 32'd0;
            r_win_cnt  <= 32'd0;
         end else begin
            r_acc     <= r_acc + w_step_val;
            r_win_cnt <= r_win_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_enable     <= 1'b0;
         r_filter     <= 8'd0;
         r_vel_window <= 32'd0;
         r_awready    <= 1'b0;
         r_bvalid     <= 1'b0;
      end else begin
         r_awready <= CP_AWVALID && CP_WVALID && !r_bvalid && !r_awready;
         if (w_wr_en) begin
            r_bvalid <= 1'b1;
            if (CP_AWADDR == c_ADDR_CTRL) begin
               if (CP_WSTRB[0]) r_enable <= CP_WDATA[0];
               if (CP_WSTRB[1]) r_filter <= CP_WDATA[15:8];
            end
            if (CP_AWADDR == c_ADDR_VWIN) begin
               for (int i = 0; i < 4; i++)
                  if (CP_WSTRB[i]) r_vel_window[8*i +: 8] <= CP_WDATA[8*i +: 8];
            end
         end else if (r_bvalid && CP_BREADY) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   always_comb begin
      w_rd_data = 64'd0;
      case (CP_ARADDR)
         c_ADDR_CTRL:   w_rd_data = {48'd0, r_filter, 7'd0, r_enable};
         c_ADDR_POS:    w_rd_data = {{32{r_pos[31]}}, r_pos};
         c_ADDR_STATUS: w_rd_data = {30'd0, r_primed, r_dir, r_err_cnt};
         c_ADDR_VWIN:   w_rd_data = {32'd0, r_vel_window};
         c_ADDR_VEL:    w_rd_data = {{32{r_velocity[31]}}, r_velocity};
         default:       w_rd_data = 64'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= 64'd0;
      end else begin
         r_arready <= CP_ARVALID && !r_rvalid && !r_arready;
         if (w_rd_en) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
         end else if (r_rvalid && CP_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign CP_AWREADY = r_awready;
   assign CP_WREADY  = r_awready;
   assign CP_BVALID  = r_bvalid;
   assign CP_BRESP   = 2'b00;
   assign CP_ARREADY = r_arready;
   assign CP_RVALID  = r_rvalid;
   assign CP_RDATA   = r_rdata;
   assign CP_RRESP   = 2'b00;

   assign w_unused = ^{CP_AWPROT, CP_ARPROT, CP_WDATA[63:32], CP_WSTRB[7:4]};

endmodule
`default_nettype wire

// File: tb/tb_encoder_decoder.sv
`default_nettype none
// Directed bench for encoder_decoder; read results are checked through a scoreboard queue.
module tb_encoder_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        encoder_a, encoder_b;
   logic [7:0]  CP_AWADDR;
   logic [2:0]  CP_AWPROT;
   logic        CP_AWVALID, CP_AWREADY;
   logic [63:0] CP_WDATA;
   logic [7:0]  CP_WSTRB;
   logic        CP_WVALID, CP_WREADY;
   logic [1:0]  CP_BRESP;
   logic        CP_BVALID, CP_BREADY;
   logic [7:0]  CP_ARADDR;
   logic [2:0]  CP_ARPROT;
   logic        CP_ARVALID, CP_ARREADY;
   logic [63:0] CP_RDATA;
   logic [1:0]  CP_RRESP;
   logic        CP_RVALID, CP_RREADY;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] sb[$];
   logic [1:0]  ab_state;

   encoder_decoder #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .encoder_a(encoder_a), .encoder_b(encoder_b),
      .CP_AWADDR(CP_AWADDR), .CP_AWPROT(CP_AWPROT), .CP_AWVALID(CP_AWVALID), .CP_AWREADY(CP_AWREADY),
      .CP_WDATA(CP_WDATA), .CP_WSTRB(CP_WSTRB), .CP_WVALID(CP_WVALID), .CP_WREADY(CP_WREADY),
      .CP_BRESP(CP_BRESP), .CP_BVALID(CP_BVALID), .CP_BREADY(CP_BREADY),
      .CP_ARADDR(CP_ARADDR), .CP_ARPROT(CP_ARPROT), .CP_ARVALID(CP_ARVALID), .CP_ARREADY(CP_ARREADY),
      .CP_RDATA(CP_RDATA), .CP_RRESP(CP_RRESP), .CP_RVALID(CP_RVALID), .CP_RREADY(CP_RREADY)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] gnext(input logic [1:0] s);
      case (s)
         2'b00:   gnext = 2'b10;
         2'b10:   gnext = 2'b11;
         2'b11:   gnext = 2'b01;
         default: gnext = 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] gprev(input logic [1:0] s);
      case (s)
         2'b00:   gprev = 2'b01;
         2'b01:   gprev = 2'b11;
         2'b11:   gprev = 2'b10;
         default: gprev = 2'b00;
      endcase
   endfunction

   task automatic drive_ab(input logic [1:0] v);
      encoder_a = v[1];
      encoder_b = v[0];
      ab_state  = v;
   endtask

   task automatic step_fwd(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         drive_ab(gnext(ab_state));
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic step_rev(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         drive_ab(gprev(ab_state));
         repeat (gap) @(negedge clk);
      end
   endtask

   // Called right after a falling edge; returns on a falling edge.
   task automatic axi_write(input logic [7:0] addr, input logic [63:0] data, input logic [7:0] strb);
      int n;
      CP_AWADDR = addr; CP_WDATA = data; CP_WSTRB = strb;
      CP_AWVALID = 1'b1; CP_WVALID = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!CP_AWREADY && n < 50);
      check("awready_timeout", {63'd0, CP_AWREADY}, 64'd1);
      @(negedge clk);
      CP_AWVALID = 1'b0; CP_WVALID = 1'b0;
      n = 0;
      while (!CP_BVALID && n < 50) begin @(negedge clk); n++; end
      check("bvalid_timeout", {63'd0, CP_BVALID}, 64'd1);
      CP_BREADY = 1'b1;
      @(negedge clk);
      CP_BREADY = 1'b0;
   endtask

   task automatic axi_read(input string tag, input logic [7:0] addr, input logic [63:0] exp);
      int n;
      logic [63:0] e;
      sb.push_back(exp);
      CP_ARADDR = addr; CP_ARVALID = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!CP_ARREADY && n < 50);
      check("arready_timeout", {63'd0, CP_ARREADY}, 64'd1);
      @(negedge clk);
      CP_ARVALID = 1'b0;
      n = 0;
      while (!CP_RVALID && n < 50) begin @(negedge clk); n++; end
      check("rvalid_timeout", {63'd0, CP_RVALID}, 64'd1);
      e = sb.pop_front();
      check(tag, CP_RDATA, e);
      CP_RREADY = 1'b1;
      @(negedge clk);
      CP_RREADY = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      encoder_a = 1'b0; encoder_b = 1'b0; ab_state = 2'b00;
      CP_AWADDR = '0; CP_AWPROT = '0; CP_AWVALID = 1'b0; CP_WDATA = '0; CP_WSTRB = '0;
      CP_WVALID = 1'b0; CP_BREADY = 1'b0; CP_ARADDR = '0; CP_ARPROT = '0;
      CP_ARVALID = 1'b0; CP_RREADY = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_awready", {63'd0, CP_AWREADY}, 64'd0);
      check("rst_wready",  {63'd0, CP_WREADY},  64'd0);
      check("rst_bvalid",  {63'd0, CP_BVALID},  64'd0);
      check("rst_arready", {63'd0, CP_ARREADY}, 64'd0);
      check("rst_rvalid",  {63'd0, CP_RVALID},  64'd0);
      check("rst_rdata",   CP_RDATA, 64'd0);
      check("rst_resp",    {60'd0, CP_BRESP, CP_RRESP}, 64'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      axi_read("pos_after_reset", 8'h08, 64'd0);
      axi_read("status_primed", 8'h10, 64'h2_0000_0000);

      // Forward then reverse counting, FILTER=0
      axi_write(8'h00, 64'h1, 8'hFF);
      step_fwd(8, 10);
      axi_read("pos_fwd8", 8'h08, 64'd8);
      axi_read("status_fwd", 8'h10, 64'h3_0000_0000);
      step_rev(3, 10);
      axi_read("pos_rev3", 8'h08, 64'd5);
      axi_read("status_rev", 8'h10, 64'h2_0000_0000);

      // Illegal double flip (10 -> 01), then clear errors
      drive_ab(2'b01);
      repeat (10) @(negedge clk);
      axi_read("status_err1", 8'h10, 64'h2_0000_0001);
      axi_read("pos_err_unch", 8'h08, 64'd5);
      axi_write(8'h00, 64'h5, 8'hFF);
      axi_read("status_clr_err", 8'h10, 64'h2_0000_0000);

      // FILTER=4: short glitch rejected, stable step accepted
      axi_write(8'h00, 64'h401, 8'hFF);
      drive_ab(2'b11);
      repeat (3) @(negedge clk);
      drive_ab(2'b01);
      repeat (15) @(negedge clk);
      axi_read("pos_glitch", 8'h08, 64'd5);
      axi_read("status_glitch", 8'h10, 64'h2_0000_0000);
      step_fwd(1, 15);
      axi_read("pos_filt_step", 8'h08, 64'd6);

      // Clear then step backwards to -1
      axi_write(8'h00, 64'h403, 8'hFF);
      axi_read("pos_cleared", 8'h08, 64'd0);
      step_rev(1, 15);
      axi_read("pos_minus1", 8'h08, 64'hFFFF_FFFF_FFFF_FFFF);

      // CLR_POS handshake lands on the same edge as the step update (FILTER=0)
      axi_write(8'h00, 64'h1, 8'hFF);
      drive_ab(gprev(ab_state));
      repeat (2) @(negedge clk);
      axi_write(8'h00, 64'h3, 8'hFF);
      repeat (10) @(negedge clk);
      axi_read("pos_clr_wins", 8'h08, 64'd0);

      // Velocity windows
      axi_write(8'h18, 64'd100, 8'hFF);
      step_fwd(25, 10);
      axi_read("vel_win100", 8'h20, 64'd10);
      axi_write(8'h18, 64'd50, 8'hFF);
      step_fwd(20, 10);
      axi_read("vel_win50", 8'h20, 64'd5);
      axi_write(8'h18, 64'd0, 8'hFF);
      step_fwd(12, 20);
      axi_read("vel_hold", 8'h20, 64'd5);
      axi_read("pos_57", 8'h08, 64'd57);

      // ENABLE=0 freezes counting but the previous state keeps tracking
      axi_write(8'h00, 64'h0, 8'hFF);
      step_fwd(2, 10);
      axi_read("pos_disabled", 8'h08, 64'd57);
      axi_write(8'h00, 64'h1, 8'hFF);
      step_fwd(1, 10);
      axi_read("pos_reenabled", 8'h08, 64'd58);
      axi_read("status_no_err", 8'h10, 64'h3_0000_0000);

      // Byte strobe on CTRL and a stalled write response
      axi_write(8'h00, 64'h400, 8'hFF);
      CP_AWADDR = 8'h00; CP_WDATA = 64'hFFFF; CP_WSTRB = 8'h01;
      CP_AWVALID = 1'b1; CP_WVALID = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!CP_AWREADY && n < 50);
      check("strb_awready", {63'd0, CP_AWREADY}, 64'd1);
      @(negedge clk);
      CP_WDATA = 64'h0; CP_WSTRB = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         check("bvalid_held", {63'd0, CP_BVALID}, 64'd1);
         check("no_second_aw", {63'd0, CP_AWREADY}, 64'd0);
         @(negedge clk);
      end
      CP_AWVALID = 1'b0; CP_WVALID = 1'b0; CP_BREADY = 1'b1;
      @(negedge clk);
      CP_BREADY = 1'b0;
      axi_read("ctrl_strb", 8'h00, 64'h401);
      axi_read("unmapped", 8'h28, 64'd0);

      // Reset during a pending read response
      CP_ARADDR = 8'h10; CP_ARVALID = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!CP_ARREADY && n < 50);
      @(negedge clk);
      CP_ARVALID = 1'b0;
      check("rvalid_pending", {63'd0, CP_RVALID}, 64'd1);
      reset = 1'b1;
      #1;
      check("rvalid_dropped", {63'd0, CP_RVALID}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("no_resp_after_rst", {62'd0, CP_RVALID, CP_BVALID}, 64'd0);
      axi_read("ctrl_after_rst", 8'h00, 64'd0);
      axi_read("vwin_after_rst", 8'h18, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
